id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NOP_OP, default `ALUOp_nop, ALUOp value loaded on reset/bubble.
REQ-003 SHALL have ports clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset); one clock, synchronous active-high reset.
REQ-004 SHALL have ports stall (in, 1, hold register) and flush (in, 1, branch/jump kill, load bubble).
REQ-005 SHALL have ID inputs: id_valid 1, id_pc XLEN, id_rs1_data XLEN, id_rs2_data XLEN, id_imm XLEN, id_rs1 5, id_rs2 5, id_rd 5, id_aluop 5, id_alusrc 1 (B=imm), id_regwrite 1, id_memread 1, id_memwrite 1.
REQ-006 SHALL have forwarding inputs: exmem_regwrite 1, exmem_rd 5, exmem_result XLEN, memwb_regwrite 1, memwb_rd 5, memwb_result XLEN.
REQ-007 SHALL have outputs to ALU/EX: ex_A XLEN, ex_B XLEN, ex_pc XLEN, ex_aluop 5, ex_store_data XLEN, ex_rd 5, ex_regwrite 1, ex_memread 1, ex_memwrite 1, ex_valid 1.
REQ-008 SHALL have output load_use (out, 1, combinational hazard request to IF/ID hold).

Function
REQ-009 SHALL compute load_use = ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & id_valid, combinationally.
REQ-010 SHALL update state on each rising clk with priority rst > flush > load_use > stall > capture.
REQ-011 SHALL on flush or load_use load a bubble: ex_valid=0, regwrite/memread/memwrite=0, ex_rd=0, aluop=NOP_OP; data fields don't-care, cleared to 0.
REQ-012 SHALL on stall (no flush, no load_use) hold all registered fields unchanged.
REQ-013 SHALL on capture register all id_* fields; latency ID->EX exactly 1 cycle.
REQ-014 SHALL on capture substitute memwb_result for id_rs1_data/id_rs2_data when memwb_regwrite & memwb_rd!=0 & memwb_rd equals that source (WB write-through).
REQ-015 SHALL form fwdA: exmem_result if exmem_regwrite & exmem_rd!=0 & exmem_rd==ex_rs1; else memwb_result on same rule with memwb; else registered rs1 data.
REQ-016 SHALL form fwdB identically for ex_rs2; EX/MEM SHALL win over MEM/WB when both match.
REQ-017 SHALL never forward for register x0; x0 source SHALL read registered value (0).
REQ-018 SHALL drive ex_A=fwdA, ex_B = registered imm if alusrc else fwdB, ex_store_data=fwdB always.
REQ-019 SHALL force ex_regwrite/ex_memread/ex_memwrite to 0 whenever ex_valid=0 (id_valid=0 captured as bubble).
REQ-020 SHALL be width-exact; no sign extension performed here (id_imm arrives extended).

Reset
REQ-021 SHALL on rst set ex_valid=0, all controls 0, ex_rd=0, ex_aluop=NOP_OP, ex_pc and data fields 0.
REQ-022 SHALL apply reset mid-stall/mid-flush with reset winning; load_use=0 the cycle after reset.

Structure
REQ-023 SHALL take ALUOp encodings and XLEN constant from the shared defines package; no local opcode copies.
REQ-024 SHALL place forwarding selection in one sub-module fwd_mux, instantiated twice (rs1, rs2).
REQ-025 SHALL keep registered fields in a single always block; hazard and forwarding purely combinational.

Verification
REQ-026 Capture: id add x3,x1,x2 with rs1=5, rs2=7, aluop=add -> next cycle ex_A=5, ex_B=7, ex_valid=1, ex_rd=3.
REQ-027 Forward priority: ex_rs1=4, exmem_rd=4 result=0x11, memwb_rd=4 result=0x22, both regwrite -> ex_A=0x11; drop exmem_regwrite -> ex_A=0x22.
REQ-028 Load-use: EX holds lw x5 (memread), ID has rs2=5 -> load_use=1, next cycle ex_valid=0, regwrite=0, aluop=NOP_OP.
REQ-029 Flush+stall same cycle: flush=1, stall=1 -> bubble loaded; stall alone 3 cycles -> ex_* unchanged 3 cycles.
REQ-030 x0/WB write-through: memwb_rd=0 result=0xFF matching rs1=0 -> ex_A=0; memwb_rd=6 result=0x99, id_rs1=6 at capture -> ex_A=0x99 after WB retires.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: datapath width, ALU opcode encodings and
// the forwarding-match rule used by the ID/EX stage.
package id_ex_stage_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;

  typedef enum logic [4:0] {
    ALUOP_NOP  = 5'd0,
    ALUOP_ADD  = 5'd1,
    ALUOP_SUB  = 5'd2,
    ALUOP_AND  = 5'd3,
    ALUOP_OR   = 5'd4,
    ALUOP_XOR  = 5'd5,
    ALUOP_SLL  = 5'd6,
    ALUOP_SRL  = 5'd7,
    ALUOP_SRA  = 5'd8,
    ALUOP_SLT  = 5'd9,
    ALUOP_SLTU = 5'd10,
    ALUOP_LUI  = 5'd11
  } aluop_e;

  // A later stage supplies a source only if it writes a real register
  // (never x0) and its destination equals that source.
  function automatic logic fwd_hit(input logic             regwrite,
                                   input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] rs);
    return regwrite && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select for one EX source register. EX/MEM is the
// younger result, so it wins over MEM/WB when both match.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic [XLEN-1:0]   i_reg_data,
  input  logic              i_exmem_regwrite,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic [XLEN-1:0]   i_exmem_result,
  input  logic              i_memwb_regwrite,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic [XLEN-1:0]   i_memwb_result,
  output logic [XLEN-1:0]   o_data
);

  // Priority select: EX/MEM, then MEM/WB, then the value captured in ID.
  always_comb begin
    o_data = i_reg_data;
    if (fwd_hit(i_exmem_regwrite, i_exmem_rd, i_rs))
      o_data = i_exmem_result;
    else if (fwd_hit(i_memwb_regwrite, i_memwb_rd, i_rs))
      o_data = i_memwb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, WB write-through
// on capture, and EX operand forwarding.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int         XLEN   = XLEN_DEF,
  parameter logic [4:0] NOP_OP = ALUOP_NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [4:0]        id_aluop,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   memwb_result,
  output logic [XLEN-1:0]   ex_A,
  output logic [XLEN-1:0]   ex_B,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_aluop,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_valid,
  output logic              load_use
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic [4:0]        r_aluop;
  logic              r_alusrc;
  logic              r_regwrite;
  logic              r_memread;
  logic              r_memwrite;

  logic              w_load_use;
  logic              w_bubble;
  logic [XLEN-1:0]   w_rs1_in;
  logic [XLEN-1:0]   w_rs2_in;
  logic [XLEN-1:0]   w_fwd_a;
  logic [XLEN-1:0]   w_fwd_b;

  // Load in EX whose destination is read by the instruction in ID: the load
  // data is not available yet, so ID must hold and EX takes a bubble.
  always_comb begin
    w_load_use = r_valid && r_memread && (r_rd != '0) &&
                 ((r_rd == id_rs1) || (r_rd == id_rs2)) && id_valid;
  end

  // Register file write in WB happens in the same cycle as the ID read, so
  // the read data may be stale; take the WB result directly on capture.
  always_comb begin
    w_rs1_in = fwd_hit(memwb_regwrite, memwb_rd, id_rs1) ? memwb_result : id_rs1_data;
    w_rs2_in = fwd_hit(memwb_regwrite, memwb_rd, id_rs2) ? memwb_result : id_rs2_data;
    // An invalid ID slot is captured as a bubble unless the stage is holding.
    w_bubble = rst || flush || w_load_use || (!stall && !id_valid);
  end

  // Pipeline register: bubble (reset/flush/load-use/empty slot), hold on
  // stall, otherwise capture the ID fields.
  always_ff @(posedge clk) begin
    if (w_bubble) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_aluop    <= NOP_OP;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
    end else if (!stall) begin
      r_valid    <= 1'b1;
      r_pc       <= id_pc;
      r_rs1_data <= w_rs1_in;
      r_rs2_data <= w_rs2_in;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_aluop    <= id_aluop;
      r_alusrc   <= id_alusrc;
      r_regwrite <= id_regwrite;
      r_memread  <= id_memread;
      r_memwrite <= id_memwrite;
    end
  end

  fwd_mux #(.XLEN(XLEN)) u_fwd_a (
    .i_rs             (r_rs1),
    .i_reg_data       (r_rs1_data),
    .i_exmem_regwrite (exmem_regwrite),
    .i_exmem_rd       (exmem_rd),
    .i_exmem_result   (exmem_result),
    .i_memwb_regwrite (memwb_regwrite),
    .i_memwb_rd       (memwb_rd),
    .i_memwb_result   (memwb_result),
    .o_data           (w_fwd_a)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_b (
    .i_rs             (r_rs2),
    .i_reg_data       (r_rs2_data),
    .i_exmem_regwrite (exmem_regwrite),
    .i_exmem_rd       (exmem_rd),
    .i_exmem_result   (exmem_result),
    .i_memwb_regwrite (memwb_regwrite),
    .i_memwb_rd       (memwb_rd),
    .i_memwb_result   (memwb_result),
    .o_data           (w_fwd_b)
  );

  // EX-side outputs; side effects are masked whenever the slot is empty.
  always_comb begin
    ex_A          = w_fwd_a;
    ex_B          = r_alusrc ? r_imm : w_fwd_b;
    ex_store_data = w_fwd_b;
    ex_pc         = r_pc;
    ex_aluop      = r_aluop;
    ex_rd         = r_rd;
    ex_valid      = r_valid;
    ex_regwrite   = r_valid && r_regwrite;
    ex_memread    = r_valid && r_memread;
    ex_memwrite   = r_valid && r_memwrite;
    load_use      = w_load_use;
  end

endmodule
